// File: rtl/vdp_pkg.sv
// -----------------------------------------------------------------------------
// vdp_pkg
// Shared definitions for the VDP host port initiator:
//   - host command op codes (OP_REG_WR .. OP_RD)
//   - VDP bus mode constants (MODE_SELECT, MODE_REG, MODE_VRAM)
//   - VDP register indices 0..17
//   - bus cycle state encoding and a helper that converts a phase length in
//     cycles into the down-counter load value
// -----------------------------------------------------------------------------
package vdp_pkg;

    typedef enum logic [1:0] {
        OP_REG_WR  = 2'd0,
        OP_VRAM_WR = 2'd1,
        OP_RAW_WR  = 2'd2,
        OP_RD      = 2'd3
    } vdp_op_e;

    localparam logic [1:0] MODE_SELECT = 2'd0;
    localparam logic [1:0] MODE_REG    = 2'd1;
    localparam logic [1:0] MODE_VRAM   = 2'd2;

    localparam logic [7:0] VRAM_WADDR_LO   = 8'd0;
    localparam logic [7:0] VRAM_WADDR_HI   = 8'd1;
    localparam logic [7:0] VRAM_RADDR_LO   = 8'd2;
    localparam logic [7:0] VRAM_RADDR_HI   = 8'd3;
    localparam logic [7:0] H_TOTAL_LO      = 8'd4;
    localparam logic [7:0] H_TOTAL_HI      = 8'd5;
    localparam logic [7:0] H_ACTIVE_LO     = 8'd6;
    localparam logic [7:0] H_ACTIVE_HI     = 8'd7;
    localparam logic [7:0] H_SYNC_START_LO = 8'd8;
    localparam logic [7:0] H_SYNC_START_HI = 8'd9;
    localparam logic [7:0] H_SYNC_LEN      = 8'd10;
    localparam logic [7:0] V_TOTAL_LO      = 8'd11;
    localparam logic [7:0] V_TOTAL_HI      = 8'd12;
    localparam logic [7:0] V_ACTIVE_LO     = 8'd13;
    localparam logic [7:0] V_ACTIVE_HI     = 8'd14;
    localparam logic [7:0] V_SYNC_START_LO = 8'd15;
    localparam logic [7:0] V_SYNC_START_HI = 8'd16;
    localparam logic [7:0] V_SYNC_LEN      = 8'd17;
    localparam int unsigned VDP_NUM_REGS   = 18;

    typedef enum logic [1:0] {
        CYC_IDLE   = 2'd0,
        CYC_SETUP  = 2'd1,
        CYC_STROBE = 2'd2,
        CYC_HOLD   = 2'd3
    } cyc_state_e;

    // A phase lasting N cycles counts N-1 down to 0.
    function automatic logic [7:0] phase_load(input int unsigned cycles);
        phase_load = 8'(cycles - 32'd1);
    endfunction

endpackage

// File: rtl/vdp_bus_cycle.sv
// -----------------------------------------------------------------------------
// vdp_bus_cycle
// Executes one timed VDP bus cycle: SETUP (mode/data driven), STROBE (read or
// write strobe high), HOLD (mode/data held, strobe low). A new start is taken
// in IDLE or on the final HOLD cycle, so a second phase follows with no gap.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   start            begin a cycle (taken only when idle or finishing HOLD)
//   start_mode/data  mode and write byte for the cycle
//   start_is_read    cycle pulses bus_read instead of bus_write, data untouched
//   bus_mode, bus_read, bus_write, bus_data_out   registered VDP bus outputs
//   cyc_busy         state is not IDLE
//   done             last HOLD cycle
//   rd_capture       last STROBE cycle of a read; sample read data this edge
// -----------------------------------------------------------------------------
module vdp_bus_cycle
    import vdp_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] start_mode,
    input  logic [7:0] start_data,
    input  logic       start_is_read,
    output logic [1:0] bus_mode,
    output logic       bus_read,
    output logic       bus_write,
    output logic [7:0] bus_data_out,
    output logic       cyc_busy,
    output logic       done,
    output logic       rd_capture
);

    localparam logic [7:0] SETUP_LOAD  = phase_load(SETUP_CYCLES);
    localparam logic [7:0] STROBE_LOAD = phase_load(STROBE_CYCLES);
    localparam logic [7:0] HOLD_LOAD   = phase_load(HOLD_CYCLES);

    cyc_state_e state_r;
    cyc_state_e state_next_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_next_s;
    logic       is_read_r;
    logic [1:0] mode_r;
    logic [7:0] data_r;
    logic       rd_r;
    logic       wr_r;
    logic       done_s;
    logic       accept_s;

    assign done_s   = (state_r == CYC_HOLD) && (cnt_r == 8'd0);
    assign accept_s = start && ((state_r == CYC_IDLE) || done_s);

    // Next state and phase counter
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            CYC_IDLE: begin
                if (accept_s) begin
                    state_next_s = CYC_SETUP;
                    cnt_next_s   = SETUP_LOAD;
                end else begin
                    state_next_s = CYC_IDLE;
                    cnt_next_s   = 8'd0;
                end
            end
            CYC_SETUP: begin
                if (cnt_r == 8'd0) begin
                    state_next_s = CYC_STROBE;
                    cnt_next_s   = STROBE_LOAD;
                end else begin
                    cnt_next_s   = cnt_r - 8'd1;
                end
            end
            CYC_STROBE: begin
                if (cnt_r == 8'd0) begin
                    state_next_s = CYC_HOLD;
                    cnt_next_s   = HOLD_LOAD;
                end else begin
                    cnt_next_s   = cnt_r - 8'd1;
                end
            end
            CYC_HOLD: begin
                if (cnt_r != 8'd0) begin
                    cnt_next_s   = cnt_r - 8'd1;
                end else if (accept_s) begin
                    state_next_s = CYC_SETUP;
                    cnt_next_s   = SETUP_LOAD;
                end else begin
                    state_next_s = CYC_IDLE;
                    cnt_next_s   = 8'd0;
                end
            end
            default: begin
                state_next_s = CYC_IDLE;
                cnt_next_s   = 8'd0;
            end
        endcase
    end

    // State, counter and registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= CYC_IDLE;
            cnt_r     <= 8'd0;
            is_read_r <= 1'b0;
            mode_r    <= 2'd0;
            data_r    <= 8'd0;
            rd_r      <= 1'b0;
            wr_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            // Mode/data only change on the edge entering SETUP; reads leave data alone.
            if (accept_s) begin
                is_read_r <= start_is_read;
                mode_r    <= start_mode;
                data_r    <= start_is_read ? data_r : start_data;
            end
            // Strobes follow STROBE state exactly, so read and write never overlap.
            rd_r <= (state_next_s == CYC_STROBE) &&  is_read_r;
            wr_r <= (state_next_s == CYC_STROBE) && !is_read_r;
        end
    end

    assign bus_mode     = mode_r;
    assign bus_data_out = data_r;
    assign bus_read     = rd_r;
    assign bus_write    = wr_r;
    assign cyc_busy     = (state_r != CYC_IDLE);
    assign done         = done_s;
    assign rd_capture   = (state_r == CYC_STROBE) && (cnt_r == 8'd0) && is_read_r;

endmodule

// File: rtl/vdp_host_bus.sv
// -----------------------------------------------------------------------------
// vdp_host_bus
// CPU-side initiator for the VDP host port. Accepts valid/ready commands and
// turns them into timed bus cycles: REG_WR (select phase, then value phase),
// VRAM_WR, RAW_WR and RD. Read data is returned on rsp_data with a one-cycle
// rsp_valid pulse.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   cmd_valid/cmd_ready              command handshake (ready only when idle)
//   cmd_op, cmd_mode, cmd_reg, cmd_data   command fields, captured at accept
//   rsp_valid, rsp_data              read response
//   busy                             bus cycle in progress
//   bus_mode, bus_read, bus_write, bus_data_out, bus_data_in   VDP bus
// Optional feature (macro VDP_HOST_SELECT_CACHE_EN): remember the last
// register select issued and skip the select phase when a REG_WR targets the
// same register. A RAW_WR/RD in select mode invalidates the cache.
// -----------------------------------------------------------------------------
module vdp_host_bus
    import vdp_pkg::*;
#(
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_mode,
    input  logic [7:0] cmd_reg,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic [1:0] bus_mode,
    output logic       bus_read,
    output logic       bus_write,
    output logic [7:0] bus_data_out,
    input  logic [7:0] bus_data_in
);

    logic       cyc_busy_s;
    logic       cyc_done_s;
    logic       rd_capture_s;
    logic       start_s;
    logic [1:0] start_mode_s;
    logic [7:0] start_data_s;
    logic       start_is_read_s;
    logic       accept_s;
    logic       skip_select_s;
    logic       phase_b_pending_r;
    logic [7:0] phase_b_data_r;
    logic       rsp_valid_r;
    logic [7:0] rsp_data_r;

    assign cmd_ready = ~cyc_busy_s & ~reset;
    assign accept_s  = cmd_valid & cmd_ready;
    assign busy      = cyc_busy_s;

`ifdef VDP_HOST_SELECT_CACHE_EN
    logic       sel_valid_r;
    logic [7:0] sel_idx_r;

    assign skip_select_s = sel_valid_r && (cmd_reg == sel_idx_r);

    // Track the register currently selected inside the VDP
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_valid_r <= 1'b0;
            sel_idx_r   <= 8'd0;
        end else if (accept_s) begin
            case (cmd_op)
                OP_REG_WR: begin
                    sel_valid_r <= 1'b1;
                    sel_idx_r   <= cmd_reg;
                end
                OP_RAW_WR, OP_RD: begin
                    // A raw select-mode cycle may have moved the VDP's selection.
                    if (cmd_mode == MODE_SELECT) begin
                        sel_valid_r <= 1'b0;
                    end
                end
                default: begin
                    sel_valid_r <= sel_valid_r;
                end
            endcase
        end
    end
`else
    assign skip_select_s = 1'b0;
`endif

    // Choose the phase to launch: a fresh command, or the value phase of a REG_WR
    always_comb begin
        start_s         = 1'b0;
        start_mode_s    = 2'd0;
        start_data_s    = 8'd0;
        start_is_read_s = 1'b0;
        if (accept_s) begin
            start_s = 1'b1;
            case (cmd_op)
                OP_REG_WR: begin
                    if (skip_select_s) begin
                        start_mode_s = MODE_REG;
                        start_data_s = cmd_data;
                    end else begin
                        start_mode_s = MODE_SELECT;
                        start_data_s = cmd_reg;
                    end
                end
                OP_VRAM_WR: begin
                    start_mode_s = MODE_VRAM;
                    start_data_s = cmd_data;
                end
                OP_RAW_WR: begin
                    start_mode_s = cmd_mode;
                    start_data_s = cmd_data;
                end
                OP_RD: begin
                    start_mode_s    = cmd_mode;
                    start_is_read_s = 1'b1;
                end
                default: begin
                    start_s = 1'b0;
                end
            endcase
        end else if (cyc_done_s && phase_b_pending_r) begin
            start_s      = 1'b1;
            start_mode_s = MODE_REG;
            start_data_s = phase_b_data_r;
        end else begin
            start_s = 1'b0;
        end
    end

    // Remember the pending value phase of a REG_WR
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_b_pending_r <= 1'b0;
            phase_b_data_r    <= 8'd0;
        end else if (accept_s) begin
            phase_b_pending_r <= (cmd_op == OP_REG_WR) && !skip_select_s;
            phase_b_data_r    <= cmd_data;
        end else if (cyc_done_s && phase_b_pending_r) begin
            phase_b_pending_r <= 1'b0;
        end
    end

    // Read response: capture on the edge leaving STROBE, pulse valid once
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= 8'd0;
        end else begin
            rsp_valid_r <= rd_capture_s;
            if (rd_capture_s) begin
                rsp_data_r <= bus_data_in;
            end
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;

    vdp_bus_cycle #(
        .SETUP_CYCLES  (SETUP_CYCLES),
        .STROBE_CYCLES (STROBE_CYCLES),
        .HOLD_CYCLES   (HOLD_CYCLES)
    ) u_bus_cycle (
        .clk           (clk),
        .reset         (reset),
        .start         (start_s),
        .start_mode    (start_mode_s),
        .start_data    (start_data_s),
        .start_is_read (start_is_read_s),
        .bus_mode      (bus_mode),
        .bus_read      (bus_read),
        .bus_write     (bus_write),
        .bus_data_out  (bus_data_out),
        .cyc_busy      (cyc_busy_s),
        .done          (cyc_done_s),
        .rd_capture    (rd_capture_s)
    );

endmodule

// File: tb/tb_vdp_host_bus.sv
// -----------------------------------------------------------------------------
// tb_vdp_host_bus
// Directed bench for vdp_host_bus with default timing (S=1, T=2, H=1) and a
// small behavioural VDP on the bus (acts on the falling edge of bus_write,
// drives read data while bus_read is high).
// -----------------------------------------------------------------------------
module tb_vdp_host_bus;
    import vdp_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [1:0] cmd_mode = 2'd0;
    logic [7:0] cmd_reg = 8'd0;
    logic [7:0] cmd_data = 8'd0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy;
    logic [1:0] bus_mode;
    logic       bus_read;
    logic       bus_write;
    logic [7:0] bus_data_out;
    logic [7:0] bus_data_in;

    int vectors = 0;
    int miscompares = 0;

    vdp_host_bus dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_mode(cmd_mode), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .bus_mode(bus_mode), .bus_read(bus_read), .bus_write(bus_write),
        .bus_data_out(bus_data_out), .bus_data_in(bus_data_in)
    );

    always #5 clk = ~clk;

    // Behavioural VDP
    logic [7:0] vdp_sel = 8'd0;
    logic [7:0] vdp_regs [0:17];
    logic [7:0] vdp_rd_byte = 8'd0;
    assign bus_data_in = bus_read ? vdp_rd_byte : 8'h00;

    always @(negedge bus_write) begin
        if (bus_mode == MODE_SELECT) vdp_sel = bus_data_out;
        else if (bus_mode == MODE_REG && vdp_sel < 8'd18) vdp_regs[vdp_sel] = bus_data_out;
    end

    // Bus monitor, sampled on the falling clock edge
    int         wr_n, rd_n, wr_hi, rd_hi, both_hi, busy_cyc, rsp_n, gap_run, gap_n;
    int         wr_w [0:7];
    logic [1:0] wr_m [0:7];
    logic [7:0] wr_d [0:7];
    int         gap [0:7];
    logic       prev_wr = 1'b0, prev_rd = 1'b0, prev_busy = 1'b0, seen_busy = 1'b0;

    always @(negedge clk) begin
        if (bus_write && !prev_wr && wr_n < 8) begin
            wr_m[wr_n] = bus_mode;
            wr_d[wr_n] = bus_data_out;
            wr_w[wr_n] = 0;
            wr_n++;
        end
        if (bus_write && wr_n > 0) wr_w[wr_n-1]++;
        if (bus_write) wr_hi++;
        if (bus_read && !prev_rd) rd_n++;
        if (bus_read) rd_hi++;
        if (bus_read && bus_write) both_hi++;
        if (busy) busy_cyc++;
        if (rsp_valid) rsp_n++;
        if (busy && !prev_busy && seen_busy && gap_n < 8) begin
            gap[gap_n] = gap_run;
            gap_n++;
        end
        if (busy) begin seen_busy = 1'b1; gap_run = 0; end
        else gap_run++;
        prev_wr = bus_write;
        prev_rd = bus_read;
        prev_busy = busy;
    end

    task automatic clear_mon();
        wr_n = 0; rd_n = 0; wr_hi = 0; rd_hi = 0; both_hi = 0;
        busy_cyc = 0; rsp_n = 0; gap_run = 0; gap_n = 0; seen_busy = 1'b0;
    endtask

    // Offer one command and hold it until accepted (bounded)
    task automatic send_cmd(input logic [1:0] op, input logic [1:0] mode,
                            input logic [7:0] rg, input logic [7:0] dat);
        int n = 0;
        cmd_op = op; cmd_mode = mode; cmd_reg = rg; cmd_data = dat;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (!cmd_ready) begin
            miscompares++;
            $display("FAIL accept_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for the bus to go idle, then let the monitor settle
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin @(negedge clk); n++; end
        vectors++;
        if (busy) begin
            miscompares++;
            $display("FAIL idle_timeout: busy=%0b required 0", busy);
        end
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready: got %0b required 0", cmd_ready); end
        vectors++;
        if ({busy, bus_read, bus_write, bus_mode, bus_data_out, rsp_valid, rsp_data} !== 21'd0) begin
            miscompares++;
            $display("FAIL rst_outputs: busy=%0b rd=%0b wr=%0b mode=%0h dout=%0h rv=%0b rd=%0h required all 0",
                     busy, bus_read, bus_write, bus_mode, bus_data_out, rsp_valid, rsp_data);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: ready=%0b busy=%0b required 1/0", cmd_ready, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reg_wr();
        clear_mon();
        send_cmd(OP_REG_WR, 2'd0, 8'd4, 8'h3F);
        wait_idle();
        vectors++;
        if (wr_n !== 2) begin miscompares++; $display("FAIL regwr_pulses: got %0d required 2", wr_n); end
        vectors++;
        if (wr_m[0] !== 2'd0 || wr_d[0] !== 8'h04) begin
            miscompares++; $display("FAIL regwr_phase_a: mode=%0h data=%0h required 0/04", wr_m[0], wr_d[0]);
        end
        vectors++;
        if (wr_m[1] !== 2'd1 || wr_d[1] !== 8'h3F) begin
            miscompares++; $display("FAIL regwr_phase_b: mode=%0h data=%0h required 1/3f", wr_m[1], wr_d[1]);
        end
        vectors++;
        if (wr_w[0] !== 2 || wr_w[1] !== 2) begin
            miscompares++; $display("FAIL regwr_width: got %0d,%0d required 2,2", wr_w[0], wr_w[1]);
        end
        vectors++;
        if (busy_cyc !== 8) begin miscompares++; $display("FAIL regwr_busy: got %0d required 8", busy_cyc); end
        vectors++;
        if (vdp_regs[H_TOTAL_LO] !== 8'h3F) begin
            miscompares++; $display("FAIL regwr_vdp_h_total: got %0h required 3f", vdp_regs[H_TOTAL_LO]);
        end
    endtask

    task automatic test_read();
        clear_mon();
        vdp_rd_byte = 8'hA5;
        send_cmd(OP_RD, 2'd1, 8'd0, 8'h00);
        wait_idle();
        vectors++;
        if (rd_n !== 1 || rd_hi !== 2) begin
            miscompares++; $display("FAIL rd_strobe: pulses=%0d cycles=%0d required 1/2", rd_n, rd_hi);
        end
        vectors++;
        if (wr_hi !== 0 || both_hi !== 0) begin
            miscompares++; $display("FAIL rd_no_write: wr=%0d both=%0d required 0/0", wr_hi, both_hi);
        end
        vectors++;
        if (rsp_n !== 1) begin miscompares++; $display("FAIL rd_rsp_valid: got %0d required 1", rsp_n); end
        vectors++;
        if (busy_cyc !== 4) begin miscompares++; $display("FAIL rd_busy: got %0d required 4", busy_cyc); end
        vectors++;
        if (bus_data_out !== 8'h3F || bus_mode !== 2'd1) begin
            miscompares++; $display("FAIL rd_bus_held: dout=%0h mode=%0h required 3f/1", bus_data_out, bus_mode);
        end
        vdp_rd_byte = 8'h5A;
        repeat (3) @(negedge clk);
        vectors++;
        if (rsp_data !== 8'hA5) begin miscompares++; $display("FAIL rd_data_held: got %0h required a5", rsp_data); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [0:2];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        clear_mon();
        cmd_op = OP_VRAM_WR;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            int n = 0;
            cmd_data = bytes[i];
            while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        wait_idle();
        vectors++;
        if (wr_n !== 3) begin miscompares++; $display("FAIL b2b_pulses: got %0d required 3", wr_n); end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (wr_m[i] !== MODE_VRAM || wr_d[i] !== bytes[i]) begin
                miscompares++;
                $display("FAIL b2b_pulse%0d: mode=%0h data=%0h required 2/%0h", i, wr_m[i], wr_d[i], bytes[i]);
            end
        end
        vectors++;
        if (gap_n !== 2 || gap[0] !== 1 || gap[1] !== 1) begin
            miscompares++; $display("FAIL b2b_idle_gap: n=%0d gaps=%0d,%0d required 2 gaps of 1", gap_n, gap[0], gap[1]);
        end
        vectors++;
        if (busy_cyc !== 12) begin miscompares++; $display("FAIL b2b_busy: got %0d required 12", busy_cyc); end
    endtask

    task automatic test_reset_abort();
        int n = 0;
        clear_mon();
        send_cmd(OP_REG_WR, 2'd0, 8'd5, 8'h77);
        while (!bus_write && n < 20) begin @(negedge clk); n++; end
        vectors++;
        if (!bus_write) begin miscompares++; $display("FAIL abort_no_strobe: bus_write=%0b required 1", bus_write); end
        reset = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (bus_write !== 1'b0 || bus_read !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_state: wr=%0b rd=%0b busy=%0b ready=%0b required 0/0/0/0",
                     bus_write, bus_read, busy, cmd_ready);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (rsp_n !== 0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL abort_after: rsp=%0d busy=%0b required 0/0", rsp_n, busy);
        end
        @(posedge clk); #1;
        clear_mon();
        send_cmd(OP_REG_WR, 2'd0, 8'd5, 8'h66);
        wait_idle();
        vectors++;
        if (wr_n !== 2 || wr_m[0] !== 2'd0 || wr_d[0] !== 8'h05 || wr_m[1] !== 2'd1 || wr_d[1] !== 8'h66) begin
            miscompares++;
            $display("FAIL abort_next_regwr: n=%0d a=%0h/%0h b=%0h/%0h required 2 0/05 1/66",
                     wr_n, wr_m[0], wr_d[0], wr_m[1], wr_d[1]);
        end
    endtask

    task automatic test_select_cache();
        int exp_n [0:3];
`ifdef VDP_HOST_SELECT_CACHE_EN
        exp_n[0] = 2; exp_n[1] = 1; exp_n[2] = 1; exp_n[3] = 2;
`else
        exp_n[0] = 2; exp_n[1] = 2; exp_n[2] = 1; exp_n[3] = 2;
`endif
        for (int i = 0; i < 4; i++) begin
            clear_mon();
            if (i == 2) send_cmd(OP_RAW_WR, 2'd0, 8'd0, 8'h02);
            else        send_cmd(OP_REG_WR, 2'd0, 8'd8, 8'h10 + 8'(i));
            wait_idle();
            vectors++;
            if (wr_n !== exp_n[i]) begin
                miscompares++; $display("FAIL cache_step%0d: pulses=%0d required %0d", i, wr_n, exp_n[i]);
            end
            vectors++;
            if (wr_n > 0 && wr_d[wr_n-1] !== ((i == 2) ? 8'h02 : 8'h10 + 8'(i))) begin
                miscompares++; $display("FAIL cache_data%0d: got %0h", i, wr_d[wr_n-1]);
            end
        end
        vectors++;
        if (vdp_regs[H_SYNC_START_LO] !== 8'h13) begin
            miscompares++; $display("FAIL cache_vdp_reg8: got %0h required 13", vdp_regs[H_SYNC_START_LO]);
        end
    endtask

    initial begin
        clear_mon();
        test_reset();
        test_reg_wr();
        test_read();
        test_back_to_back();
        test_reset_abort();
        test_select_cache();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
